// File: rtl/id_stage.sv
// Instruction-decode stage of the RV32I pipeline: register file with write-first
// bypass, control/immediate decode, load-use hazard detection and the ID/EX register.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic [XLEN-1:0] IF_PC,
  input  logic [31:0]     IF_instruction,
  input  logic            EX_isBranchTaken,
  input  logic            WB_regWrite,
  input  logic [4:0]      WB_rd,
  input  logic [XLEN-1:0] WB_data,
  output logic            stall,
  output logic            ID_valid,
  output logic [XLEN-1:0] ID_PC,
  output logic [XLEN-1:0] ID_rs1Val,
  output logic [XLEN-1:0] ID_rs2Val,
  output logic [XLEN-1:0] ID_imm,
  output logic [4:0]      ID_rs1,
  output logic [4:0]      ID_rs2,
  output logic [4:0]      ID_rd,
  output logic [2:0]      ID_funct3,
  output logic [3:0]      ID_aluOp,
  output logic            ID_aluSrc,
  output logic            ID_memRead,
  output logic            ID_memWrite,
  output logic            ID_regWrite,
  output logic            ID_memToReg,
  output logic            ID_branch,
  output logic            ID_jump
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // funct7[5] only selects SUB for register-register ops; shifts use it for both forms
  function automatic logic [3:0] alu_op_f(input logic [2:0] f3, input logic f7b5,
                                          input logic is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [XLEN-1:0] regs_r [NREG];
  logic            squash_r;

  logic [6:0]      opcode_s;
  logic [4:0]      rs1_idx_s, rs2_idx_s, rd_idx_s;
  logic [2:0]      funct3_s;
  logic [XLEN-1:0] rs1_val_s, rs2_val_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, imm_s;
  logic [3:0]      alu_op_s;
  logic            alu_src_s, mem_read_s, mem_write_s, reg_write_s;
  logic            mem_to_reg_s, branch_s, jump_s, uses_rs1_s, uses_rs2_s;
  logic            hazard_s, bubble_s;

  assign opcode_s  = IF_instruction[6:0];
  assign rd_idx_s  = IF_instruction[11:7];
  assign funct3_s  = IF_instruction[14:12];
  assign rs1_idx_s = IF_instruction[19:15];
  assign rs2_idx_s = IF_instruction[24:20];

  assign imm_i_s = {{20{IF_instruction[31]}}, IF_instruction[31:20]};
  assign imm_s_s = {{20{IF_instruction[31]}}, IF_instruction[31:25], IF_instruction[11:7]};
  assign imm_b_s = {{19{IF_instruction[31]}}, IF_instruction[31], IF_instruction[7],
                    IF_instruction[30:25], IF_instruction[11:8], 1'b0};
  assign imm_u_s = {IF_instruction[31:12], 12'h000};
  assign imm_j_s = {{11{IF_instruction[31]}}, IF_instruction[31], IF_instruction[19:12],
                    IF_instruction[20], IF_instruction[30:21], 1'b0};

  // Register file write port; x0 is never written
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
    end else if (WB_regWrite && (WB_rd != 5'd0)) begin
      regs_r[WB_rd] <= WB_data;
    end
  end

  // Operand reads with write-first bypass from writeback
  always_comb begin
    rs1_val_s = '0;
    rs2_val_s = '0;
    if (rs1_idx_s == 5'd0) begin
      rs1_val_s = '0;
    end else if (WB_regWrite && (WB_rd == rs1_idx_s)) begin
      rs1_val_s = WB_data;
    end else begin
      rs1_val_s = regs_r[rs1_idx_s];
    end
    if (rs2_idx_s == 5'd0) begin
      rs2_val_s = '0;
    end else if (WB_regWrite && (WB_rd == rs2_idx_s)) begin
      rs2_val_s = WB_data;
    end else begin
      rs2_val_s = regs_r[rs2_idx_s];
    end
  end

  // Control and immediate decode by opcode
  always_comb begin
    alu_op_s     = ALU_ADD;
    alu_src_s    = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    uses_rs1_s   = 1'b0;
    uses_rs2_s   = 1'b0;
    imm_s        = '0;
    case (opcode_s)
      OPC_OP: begin
        alu_op_s    = alu_op_f(funct3_s, IF_instruction[30], 1'b1);
        reg_write_s = 1'b1;
        uses_rs1_s  = 1'b1;
        uses_rs2_s  = 1'b1;
      end
      OPC_OPIMM: begin
        alu_op_s    = alu_op_f(funct3_s, IF_instruction[30], 1'b0);
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        uses_rs1_s  = 1'b1;
        imm_s       = imm_i_s;
      end
      OPC_LOAD: begin
        alu_src_s    = 1'b1;
        mem_read_s   = 1'b1;
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        uses_rs1_s   = 1'b1;
        imm_s        = imm_i_s;
      end
      OPC_STORE: begin
        alu_src_s   = 1'b1;
        mem_write_s = 1'b1;
        uses_rs1_s  = 1'b1;
        uses_rs2_s  = 1'b1;
        imm_s       = imm_s_s;
      end
      OPC_BRANCH: begin
        alu_op_s   = ALU_SUB;
        branch_s   = 1'b1;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b1;
        imm_s      = imm_b_s;
      end
      OPC_JAL: begin
        jump_s      = 1'b1;
        reg_write_s = 1'b1;
        imm_s       = imm_j_s;
      end
      OPC_JALR: begin
        jump_s      = 1'b1;
        reg_write_s = 1'b1;
        alu_src_s   = 1'b1;
        uses_rs1_s  = 1'b1;
        imm_s       = imm_i_s;
      end
      OPC_LUI: begin
        alu_op_s    = ALU_PASSB;
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        imm_s       = imm_u_s;
      end
      OPC_AUIPC: begin
        alu_src_s   = 1'b1;
        reg_write_s = 1'b1;
        imm_s       = imm_u_s;
      end
      default: begin
        alu_op_s = ALU_ADD;
        imm_s    = '0;
      end
    endcase
  end

  // Load-use hazard against the load now sitting in ID/EX; flush and squash override it
  always_comb begin
    hazard_s = 1'b0;
    if (ID_valid && ID_memRead && (ID_rd != 5'd0)) begin
      hazard_s = (uses_rs1_s && (ID_rd == rs1_idx_s)) ||
                 (uses_rs2_s && (ID_rd == rs2_idx_s));
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign stall    = rst && hazard_s && !squash_r && !EX_isBranchTaken;
  assign bubble_s = EX_isBranchTaken || squash_r || stall;

  // ID/EX pipeline register; bubbles keep datapath fields but zero valid and control
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      squash_r    <= 1'b0;
      ID_valid    <= 1'b0;
      ID_PC       <= '0;
      ID_rs1Val   <= '0;
      ID_rs2Val   <= '0;
      ID_imm      <= '0;
      ID_rs1      <= 5'd0;
      ID_rs2      <= 5'd0;
      ID_rd       <= 5'd0;
      ID_funct3   <= 3'd0;
      ID_aluOp    <= 4'd0;
      ID_aluSrc   <= 1'b0;
      ID_memRead  <= 1'b0;
      ID_memWrite <= 1'b0;
      ID_regWrite <= 1'b0;
      ID_memToReg <= 1'b0;
      ID_branch   <= 1'b0;
      ID_jump     <= 1'b0;
    end else begin
      squash_r  <= EX_isBranchTaken;
      ID_PC     <= IF_PC;
      ID_rs1Val <= rs1_val_s;
      ID_rs2Val <= rs2_val_s;
      ID_imm    <= imm_s;
      ID_rs1    <= rs1_idx_s;
      ID_rs2    <= rs2_idx_s;
      ID_rd     <= rd_idx_s;
      ID_funct3 <= funct3_s;
      if (bubble_s) begin
        ID_valid    <= 1'b0;
        ID_aluOp    <= 4'd0;
        ID_aluSrc   <= 1'b0;
        ID_memRead  <= 1'b0;
        ID_memWrite <= 1'b0;
        ID_regWrite <= 1'b0;
        ID_memToReg <= 1'b0;
        ID_branch   <= 1'b0;
        ID_jump     <= 1'b0;
      end else begin
        ID_valid    <= 1'b1;
        ID_aluOp    <= alu_op_s;
        ID_aluSrc   <= alu_src_s;
        ID_memRead  <= mem_read_s;
        ID_memWrite <= mem_write_s;
        ID_regWrite <= reg_write_s;
        ID_memToReg <= mem_to_reg_s;
        ID_branch   <= branch_s;
        ID_jump     <= jump_s;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expectations are queued when an instruction is driven
// and checked one clk1 edge later against a small register-file model.
module tb_id_stage;

  logic        clk1;
  logic        rst;
  logic [31:0] IF_PC, IF_instruction;
  logic        EX_isBranchTaken;
  logic        WB_regWrite;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data;
  logic        stall, ID_valid;
  logic [31:0] ID_PC, ID_rs1Val, ID_rs2Val, ID_imm;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic [2:0]  ID_funct3;
  logic [3:0]  ID_aluOp;
  logic        ID_aluSrc, ID_memRead, ID_memWrite, ID_regWrite, ID_memToReg, ID_branch, ID_jump;

  id_stage dut (
    .clk1(clk1), .rst(rst), .IF_PC(IF_PC), .IF_instruction(IF_instruction),
    .EX_isBranchTaken(EX_isBranchTaken), .WB_regWrite(WB_regWrite), .WB_rd(WB_rd),
    .WB_data(WB_data), .stall(stall), .ID_valid(ID_valid), .ID_PC(ID_PC),
    .ID_rs1Val(ID_rs1Val), .ID_rs2Val(ID_rs2Val), .ID_imm(ID_imm), .ID_rs1(ID_rs1),
    .ID_rs2(ID_rs2), .ID_rd(ID_rd), .ID_funct3(ID_funct3), .ID_aluOp(ID_aluOp),
    .ID_aluSrc(ID_aluSrc), .ID_memRead(ID_memRead), .ID_memWrite(ID_memWrite),
    .ID_regWrite(ID_regWrite), .ID_memToReg(ID_memToReg), .ID_branch(ID_branch),
    .ID_jump(ID_jump)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // ctl packing: {aluSrc, memRead, memWrite, regWrite, memToReg, branch, jump}
  localparam logic [6:0] C_SRC = 7'b1000000;
  localparam logic [6:0] C_MR  = 7'b0100000;
  localparam logic [6:0] C_MW  = 7'b0010000;
  localparam logic [6:0] C_RW  = 7'b0001000;
  localparam logic [6:0] C_M2R = 7'b0000100;
  localparam logic [6:0] C_BR  = 7'b0000010;
  localparam logic [6:0] C_J   = 7'b0000001;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  aluop;
    logic [6:0]  ctl;
    logic        imm_dc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rf [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (WB_regWrite && (WB_rd == idx)) return WB_data;
    return model_rf[idx];
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic flush);
    IF_PC            = pc;
    IF_instruction   = instr;
    EX_isBranchTaken = flush;
  endtask

  task automatic push_exp(input logic [31:0] imm, input logic [3:0] aluop,
                          input logic [6:0] ctl, input logic imm_dc);
    exp_t e;
    logic [31:0] ins;
    ins      = IF_instruction;
    e.valid  = 1'b1;
    e.pc     = IF_PC;
    e.rs1    = ins[19:15];
    e.rs2    = ins[24:20];
    e.rd     = ins[11:7];
    e.rs1v   = model_read(ins[19:15]);
    e.rs2v   = model_read(ins[24:20]);
    e.imm    = imm;
    e.aluop  = aluop;
    e.ctl    = ctl;
    e.imm_dc = imm_dc;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e        = '{default: '0};
    e.valid  = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("valid", {31'd0, ID_valid}, {31'd0, e.valid});
      chk("ctl", {25'd0, ID_aluSrc, ID_memRead, ID_memWrite, ID_regWrite, ID_memToReg,
                  ID_branch, ID_jump}, {25'd0, e.ctl});
      if (e.valid) begin
        chk("pc", ID_PC, e.pc);
        chk("rs1", {27'd0, ID_rs1}, {27'd0, e.rs1});
        chk("rs2", {27'd0, ID_rs2}, {27'd0, e.rs2});
        chk("rd", {27'd0, ID_rd}, {27'd0, e.rd});
        chk("rs1val", ID_rs1Val, e.rs1v);
        chk("rs2val", ID_rs2Val, e.rs2v);
        chk("aluop", {28'd0, ID_aluOp}, {28'd0, e.aluop});
        if (!e.imm_dc) chk("imm", ID_imm, e.imm);
      end else begin
        chk("bubble_aluop", {28'd0, ID_aluOp}, 32'd0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    if (WB_regWrite && (WB_rd != 5'd0)) model_rf[WB_rd] = WB_data;
    @(negedge clk1);
    WB_regWrite = 1'b0;
    WB_rd       = 5'd0;
    WB_data     = 32'h0;
    check_sb();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
  endtask

  initial begin
    rst = 1'b0;
    IF_PC = 32'h0; IF_instruction = 32'h0; EX_isBranchTaken = 1'b0;
    WB_regWrite = 1'b0; WB_rd = 5'd0; WB_data = 32'h0;
    clear_model();
    repeat (2) @(negedge clk1);
    chk("rst_valid", {31'd0, ID_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pc", ID_PC, 32'd0);
    chk("rst_imm", ID_imm, 32'd0);
    chk("rst_ctl", {25'd0, ID_aluSrc, ID_memRead, ID_memWrite, ID_regWrite, ID_memToReg,
                    ID_branch, ID_jump}, 32'd0);
    rst = 1'b1;

    // ADDI x1,x0,5
    drive(32'h0, 32'h00500093, 1'b0); push_exp(32'd5, 4'd0, C_SRC | C_RW, 1'b0); tick();
    // SW x2,8(x1) with same-cycle writeback of x1 (bypass)
    drive(32'h4, 32'h0020A423, 1'b0);
    WB_regWrite = 1'b1; WB_rd = 5'd1; WB_data = 32'h64;
    push_exp(32'd8, 4'd0, C_SRC | C_MW, 1'b0); tick();

    // LW x2,0(x1) then dependent ADD x3,x2,x1 -> stall, bubble, replay
    drive(32'h8, 32'h0000A103, 1'b0); push_exp(32'd0, 4'd0, C_SRC | C_MR | C_RW | C_M2R, 1'b0); tick();
    drive(32'hC, 32'h001101B3, 1'b0); #1 chk("stall_loaduse", {31'd0, stall}, 32'd1);
    push_bubble(); tick();
    #1 chk("stall_replay", {31'd0, stall}, 32'd0);
    push_exp(32'd0, 4'd0, C_RW, 1'b0); tick();

    // Flush coinciding with a load-use hazard: flush wins, two bubbles, then normal
    drive(32'h10, 32'h0000A103, 1'b0); push_exp(32'd0, 4'd0, C_SRC | C_MR | C_RW | C_M2R, 1'b0); tick();
    drive(32'h14, 32'h001101B3, 1'b1); #1 chk("stall_flush", {31'd0, stall}, 32'd0);
    push_bubble(); tick();
    drive(32'h18, 32'h0010E333, 1'b0); #1 chk("stall_squash", {31'd0, stall}, 32'd0);
    push_bubble(); tick();
    drive(32'h40, 32'h40208233, 1'b0); push_exp(32'd0, 4'd1, C_RW, 1'b0); tick();

    // Immediate formats and ALU-op selection
    drive(32'h44, 32'h123452B7, 1'b0); push_exp(32'h12345000, 4'd10, C_SRC | C_RW, 1'b0); tick();
    drive(32'h48, 32'h4030D393, 1'b0); push_exp(32'h00000403, 4'd7, C_SRC | C_RW, 1'b0); tick();
    drive(32'h4C, 32'hFFF00413, 1'b0); push_exp(32'hFFFFFFFF, 4'd0, C_SRC | C_RW, 1'b0); tick();
    drive(32'h50, 32'hFE008EE3, 1'b0); push_exp(32'hFFFFFFFC, 4'd1, C_BR, 1'b0); tick();
    drive(32'h54, 32'h008000EF, 1'b0); push_exp(32'h00000008, 4'd0, C_J | C_RW, 1'b0); tick();
    drive(32'h58, 32'hFFFFFFFF, 1'b0); push_exp(32'h0, 4'd0, 7'd0, 1'b1); tick();

    // Writes to x0 are ignored, including the bypass path
    drive(32'h5C, 32'h00000013, 1'b0);
    WB_regWrite = 1'b1; WB_rd = 5'd0; WB_data = 32'hFFFFFFFF;
    push_exp(32'd0, 4'd0, C_SRC | C_RW, 1'b0); tick();
    drive(32'h60, 32'h00000533, 1'b0); push_exp(32'd0, 4'd0, C_RW, 1'b0); tick();

    // Asynchronous reset in the middle of a stall
    drive(32'h64, 32'h0000A103, 1'b0); push_exp(32'd0, 4'd0, C_SRC | C_MR | C_RW | C_M2R, 1'b0); tick();
    drive(32'h68, 32'h001101B3, 1'b0); #1 chk("stall_pre_rst", {31'd0, stall}, 32'd1);
    #1 rst = 1'b0;
    #1 chk("rst_async_stall", {31'd0, stall}, 32'd0);
    chk("rst_async_valid", {31'd0, ID_valid}, 32'd0);
    chk("rst_async_ctl", {25'd0, ID_aluSrc, ID_memRead, ID_memWrite, ID_regWrite, ID_memToReg,
                          ID_branch, ID_jump}, 32'd0);
    clear_model();
    @(negedge clk1);
    rst = 1'b1;
    // ADDI x11,x1,0 must see the cleared x1
    drive(32'h6C, 32'h00008593, 1'b0); push_exp(32'd0, 4'd0, C_SRC | C_RW, 1'b0); tick();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Consumes IF_PC/IF_instruction.
- Owns the 32x32 architectural register file, with a writeback port from WB.
- Decodes control fields and generates the immediate.
- Detects load-use hazards, driving the fetch stall.
- Registers everything into the ID/EX pipeline register consumed by EX.

Parameters:
XLEN, 32, datapath width
NREG, 32, register count (x0 hardwired zero)

Ports:
clk1  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
IF_PC  in  32  PC of fetched instruction
IF_instruction  in  32  fetched instruction word
EX_isBranchTaken  in  1  flush request from EX
WB_regWrite  in  1  writeback enable
WB_rd  in  5  writeback destination
WB_data  in  32  writeback value
stall  out  1  load-use stall to fetch stage (combinational)
ID_valid  out  1  ID/EX holds a real instruction
ID_PC  out  32  registered PC
ID_rs1Val, ID_rs2Val  out  32 each  operand values
ID_imm  out  32  sign-extended immediate
ID_rs1, ID_rs2, ID_rd  out  5 each  register indices
ID_funct3  out  3  funct3 field
ID_aluOp  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
ID_aluSrc  out  1  1 = immediate operand B
ID_memRead, ID_memWrite, ID_regWrite, ID_memToReg, ID_branch, ID_jump  out  1 each  control

Behaviour:
- Reset (rst=0, asynchronous):
  - All ID_* outputs 0; ID_valid 0; squash flag 0; all 32 registers cleared to 0.
  - stall is 0 while in reset.
- Latency: one clk1 edge from IF inputs to ID_* outputs.
- Register file:
  - Write on posedge when WB_regWrite=1 and WB_rd!=0.
  - Writes to x0 are ignored.
- Register file reads:
  - Combinational from IF_instruction[19:15] and [24:20].
  - Write-first bypass: if WB_regWrite=1, WB_rd!=0 and WB_rd equals the read index, WB_data is returned.
  - Index 0 always reads 0.
- Decode by opcode:
  - OP: aluOp from funct3/funct7[5].
  - OP-IMM: aluSrc=1; SRAI selects via funct7[5]; SUB never from OP-IMM.
  - LOAD: memRead, memToReg, regWrite, aluSrc, ADD.
  - STORE: memWrite, aluSrc, ADD.
  - BRANCH: branch, SUB.
  - JAL and JALR: jump, regWrite; JALR also aluSrc.
  - LUI: regWrite, aluSrc, PASSB.
  - AUIPC: regWrite, aluSrc, ADD.
  - Unknown opcode: all control 0, ID_valid=1.
- Immediates: I, S, B, U, J formats, sign-extended from instr[31]; B and J have bit0=0.
- Load-use hazard: stall=1 when all of the following hold:
  - ID_valid=1 and ID_memRead=1 and ID_rd!=0;
  - ID_rd equals the incoming rs1 (opcodes that read rs1) or rs2 (OP/STORE/BRANCH);
  - squash is not active.
- While stall=1: the ID/EX register loads a bubble (ID_valid=0, all control 0). Fetch holds, so the same instruction is re-presented the next cycle.
- Flush when EX_isBranchTaken=1:
  - ID/EX loads a bubble at that edge.
  - The squash flag is set, so the instruction presented on the following cycle (wrong-path, already latched by fetch) is also loaded as a bubble. The flag then clears.
- Priority: reset > flush > squash > load-use bubble > normal load.
- Flush and hazard together: flush wins, stall=0.
- Bubbles carry ID_PC of the squashed instruction (don't-care for EX); ID_regWrite=0 is guaranteed.
- Reset asserted mid-stall or mid-squash: all state cleared immediately, with no residual stall.

Test Plan:
1. Reset then release; IF_PC=0, IF_instruction=0x00500093 (ADDI x1,x0,5) -> next edge: ID_valid=1, ID_rd=1, ID_imm=5, ID_aluSrc=1, ID_regWrite=1, ID_aluOp=0, ID_rs1Val=0.
2. WB_regWrite=1, WB_rd=1, WB_data=0x64 in the same cycle as IF_instruction=0x0020A423 (SW x2,8(x1)) -> ID_rs1Val=0x64 (bypass), ID_imm=8, ID_memWrite=1, ID_regWrite=0.
3. LW x2,0(x1) (0x0000A103) followed by ADD x3,x2,x1 (0x001101B3) -> after the LW edge, stall=1; next edge loads a bubble (ID_valid=0); following edge ID_rd=3, stall=0.
4. EX_isBranchTaken=1 for one cycle with a valid instruction presented -> two consecutive bubbles; third instruction decodes normally.
5. WB_regWrite=1, WB_rd=0, WB_data=0xFFFFFFFF, then read x0 -> ID_rs1Val=0.
6. Assert rst low asynchronously mid-stall -> stall, ID_valid and all control drop to 0 without a clock edge; after release, x1 reads 0.
